// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: next-PC source select,
// sequencer state, and the load-use hazard detection helper.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_SEL_SEQ = 2'd0,
        PC_SEL_BR  = 2'd1,
        PC_SEL_JMP = 2'd2,
        PC_SEL_EXC = 2'd3
    } pc_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

    // A load in EX feeding a source register of the instruction in ID; r0 never hazards.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ld_rt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return mem_read && (ld_rt != 5'd0) &&
               ((ld_rt == rs) || (uses_rt && (ld_rt == rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// Loadable down-counter tracking the remaining mult/div occupancy.
// Clear wins over load; decrement stops at zero.
module md_busy_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Occupancy counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritises exceptions, taken
// branches, load-use and mult/div hazards and ID jumps, and selects the next PC.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_md_start,
    input  logic             id_md_use,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             exc_req,
    output logic             pc_wr_en,
    output logic [1:0]       pc_sel,
    output logic             if_id_wr_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_busy,
    output logic             md_abort,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    hz_state_e        state_r;
    hz_state_e        state_nxt_s;
    logic             load_use_s;
    logic             md_stall_s;
    logic             evt_block_s;
    logic             md_load_s;
    logic             md_clear_s;
    logic             md_dec_s;
    logic             md_zero_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign load_use_s  = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
    assign md_stall_s  = (state_r == MD_WAIT) && (id_md_start || id_md_use);
    assign evt_block_s = exc_req || ex_branch_taken || load_use_s || md_stall_s;
    assign md_dec_s    = (state_r == MD_WAIT);

    md_busy_timer #(
        .W (MD_W)
    ) u_md_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (md_clear_s),
        .load       (md_load_s),
        .load_value (MD_W'(MD_LATENCY - 1)),
        .dec        (md_dec_s),
        .zero       (md_zero_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and occupancy timer control.
    always_comb begin
        state_nxt_s = state_r;
        md_load_s   = 1'b0;
        md_clear_s  = 1'b0;
        case (state_r)
            RUN: begin
                if (id_md_start && !evt_block_s) begin
                    state_nxt_s = MD_WAIT;
                    md_load_s   = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MD_WAIT: begin
                // An exception cancels the in-flight op; a taken branch does not (it is younger).
                if (exc_req) begin
                    state_nxt_s = RUN;
                    md_clear_s  = 1'b1;
                end else if (md_zero_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = MD_WAIT;
                end
            end
            default: begin
                state_nxt_s = RUN;
                md_clear_s  = 1'b1;
            end
        endcase
    end

    // Priority-resolved pipeline control outputs, forced low during reset.
    always_comb begin
        pc_wr_en     = 1'b0;
        pc_sel       = PC_SEL_SEQ;
        if_id_wr_en  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        md_abort     = 1'b0;
        if (!reset) begin
            md_busy = (state_r == MD_WAIT);
            if (exc_req) begin
                pc_sel       = PC_SEL_EXC;
                pc_wr_en     = 1'b1;
                if_id_wr_en  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                md_abort     = (state_r == MD_WAIT);
            end else if (ex_branch_taken) begin
                pc_sel      = PC_SEL_BR;
                pc_wr_en    = 1'b1;
                if_id_wr_en = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use_s || md_stall_s) begin
                id_ex_flush = 1'b1;
            end else if (id_jump) begin
                pc_sel      = PC_SEL_JMP;
                pc_wr_en    = 1'b1;
                if_id_wr_en = 1'b1;
                if_id_flush = 1'b1;
            end else begin
                pc_wr_en    = 1'b1;
                if_id_wr_en = 1'b1;
            end
        end else begin
            md_busy = 1'b0;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_wr_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// random traffic against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

    localparam int MD_LAT  = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, id_jump, id_md_start, id_md_use;
    logic          ex_mem_read, ex_branch_taken, exc_req;
    logic          pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic          md_busy, md_abort;
    logic [1:0]    pc_sel;
    logic [CW-1:0] stall_cnt;

    int total;
    int bad;
    int cyc;
    int md_left;   // remaining mult/div busy cycles in the model
    int exp_cnt;   // model stall counter
    int base_cnt;

    pipeline_hazard_ctrl #(
        .MD_LATENCY (MD_LAT),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .id_md_start     (id_md_start),
        .id_md_use       (id_md_use),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .exc_req         (exc_req),
        .pc_wr_en        (pc_wr_en),
        .pc_sel          (pc_sel),
        .if_id_wr_en     (if_id_wr_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .md_busy         (md_busy),
        .md_abort        (md_abort),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_jump = 1'b0; id_md_start = 1'b0; id_md_use = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; exc_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc_wr_en"}, int'(pc_wr_en), 0);
        chk({tag, "_pc_sel"}, int'(pc_sel), 0);
        chk({tag, "_if_id_wr_en"}, int'(if_id_wr_en), 0);
        chk({tag, "_flushes"}, int'({if_id_flush, id_ex_flush, ex_mem_flush}), 0);
        chk({tag, "_md_busy"}, int'(md_busy), 0);
        chk({tag, "_md_abort"}, int'(md_abort), 0);
        chk({tag, "_stall_cnt"}, int'(stall_cnt), 0);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic run_cycle();
        bit busy, lu, hold;
        int e_pcw, e_ifw, e_sel, e_iff, e_idf, e_exf, e_abort;
        #1;
        busy = (md_left > 0);
        lu = ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        hold = lu || (busy && (id_md_start || id_md_use));
        e_pcw = 1; e_ifw = 1; e_sel = 0; e_iff = 0; e_idf = 0; e_exf = 0; e_abort = 0;
        if (exc_req) begin
            e_sel = 3; e_iff = 1; e_idf = 1; e_exf = 1; e_abort = busy ? 1 : 0;
        end else if (ex_branch_taken) begin
            e_sel = 1; e_iff = 1; e_idf = 1;
        end else if (hold) begin
            e_pcw = 0; e_ifw = 0; e_idf = 1;
        end else if (id_jump) begin
            e_sel = 2; e_iff = 1;
        end
        chk("pc_wr_en", int'(pc_wr_en), e_pcw);
        chk("pc_sel", int'(pc_sel), e_sel);
        chk("if_id_wr_en", int'(if_id_wr_en), e_ifw);
        chk("if_id_flush", int'(if_id_flush), e_iff);
        chk("id_ex_flush", int'(id_ex_flush), e_idf);
        chk("ex_mem_flush", int'(ex_mem_flush), e_exf);
        chk("md_busy", int'(md_busy), busy ? 1 : 0);
        chk("md_abort", int'(md_abort), e_abort);
        chk("stall_cnt", int'(stall_cnt), exp_cnt);
        @(posedge clk);
        if (exc_req) md_left = 0;
        else if (busy) md_left = md_left - 1;
        else if (id_md_start && !ex_branch_taken && !lu) md_left = MD_LAT;
        if ((e_pcw == 0) && (exp_cnt < CNT_MAX)) exp_cnt = exp_cnt + 1;
        cyc++;
        #1;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; md_left = 0; exp_cnt = 0;
        idle_inputs();
        reset = 1'b1;
        // Outputs stay low under reset even with an active event.
        ex_branch_taken = 1'b1;
        #2;
        chk_all_zero("reset");
        #5;
        reset = 1'b0;
        idle_inputs();

        // Idle stream.
        for (int i = 0; i < 10; i++) run_cycle();

        // Load-use on rs, then a load to r0 which never hazards.
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        run_cycle();
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        ex_rt = 5'd0; id_rs = 5'd0;
        run_cycle();
        // Load-use through rt only when rt is a source.
        ex_rt = 5'd9; id_rs = 5'd1; id_rt = 5'd9; id_uses_rt = 1'b0;
        run_cycle();
        id_uses_rt = 1'b1;
        run_cycle();
        idle_inputs();

        // Branch beats concurrent load-use and jump.
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_jump = 1'b1;
        run_cycle();
        idle_inputs();
        id_jump = 1'b1;
        run_cycle();
        idle_inputs();

        // Mult/div occupancy: issue, one filler, then mfhi held until it issues.
        base_cnt = int'(stall_cnt);
        id_md_start = 1'b1;
        run_cycle();
        idle_inputs();
        run_cycle();
        id_md_use = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle();
        idle_inputs();
        chk("md_stall_delta", int'(stall_cnt) - base_cnt, 3);

        // Back-to-back mult/div: second start stalls until the first drains.
        id_md_start = 1'b1;
        for (int i = 0; i < 6; i++) run_cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) run_cycle();

        // Exception in the second busy cycle aborts the op.
        id_md_start = 1'b1;
        run_cycle();
        idle_inputs();
        run_cycle();
        exc_req = 1'b1;
        run_cycle();
        idle_inputs();
        chk("md_busy_after_exc", int'(md_busy), 0);
        run_cycle();

        // Branch during occupancy does not abort.
        id_md_start = 1'b1;
        run_cycle();
        idle_inputs();
        ex_branch_taken = 1'b1;
        run_cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) run_cycle();

        // Saturation of the stall counter.
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        for (int i = 0; i < 20; i++) run_cycle();
        chk("stall_cnt_sat", int'(stall_cnt), CNT_MAX);
        idle_inputs();

        // Release saturation with a reset so random traffic exercises counting again.
        reset = 1'b1;
        #1;
        md_left = 0; exp_cnt = 0;
        chk_all_zero("reset_sat");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_rt           = 5'($urandom_range(0, 5));
            id_rs           = 5'($urandom_range(0, 5));
            id_rt           = 5'($urandom_range(0, 5));
            id_uses_rt      = ($urandom_range(0, 1) == 1);
            id_jump         = ($urandom_range(0, 7) == 0);
            id_md_start     = ($urandom_range(0, 5) == 0);
            id_md_use       = ($urandom_range(0, 4) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            exc_req         = ($urandom_range(0, 24) == 0);
            run_cycle();
        end
        idle_inputs();

        // Reset while mult/div is busy: immediate quiet outputs, no abort.
        id_md_start = 1'b1;
        run_cycle();
        idle_inputs();
        run_cycle();
        exc_req = 1'b1; id_md_use = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
        reset = 1'b1;
        #1;
        md_left = 0; exp_cnt = 0;
        chk_all_zero("reset_md");
        @(posedge clk);
        #2;
        chk_all_zero("reset_md_hold");
        reset = 1'b0;
        idle_inputs();
        run_cycle();
        chk("post_reset_md_busy", int'(md_busy), 0);
        for (int i = 0; i < 3; i++) run_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
